// File: rtl/dff_pipe.sv
// dff_pipe: multi-stage valid-tagged pipeline register with stall, flush, tap and occupancy
`timescale 1ns/1ps
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int OCC_W = $clog2(DEPTH+1),
  parameter int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             VI,
  output logic [WIDTH-1:0] Q,
  output logic             VO,
  input  logic [TAP_W-1:0] TAP_SEL,
  output logic [WIDTH-1:0] TAP,
  output logic             TAP_V,
  output logic [OCC_W-1:0] OCC
);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [OCC_W-1:0] occ;
  // reset beats flush beats shift; flush drops valids but keeps data, occupancy tracks entry minus exit
  always_ff @(posedge C) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      v <= '0;
      occ <= '0;
    end else if (FLUSH) begin
      v <= '0;
      occ <= '0;
    end else if (EN) begin
      data[0] <= D;
      v[0] <= VI;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        v[i] <= v[i-1];
      end
      occ <= occ + OCC_W'(VI) - OCC_W'(v[DEPTH-1]);
    end
  end
  // tap mux; selections past the last stage read as the reset value with no valid
  always_comb begin
    TAP = RESET_VAL;
    TAP_V = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (TAP_SEL == TAP_W'(i)) begin
        TAP = data[i];
        TAP_V = v[i];
      end
  end
  assign Q = data[DEPTH-1];
  assign VO = v[DEPTH-1];
  assign OCC = occ;
`ifndef SYNTHESIS
  // occupancy must stay within 0..DEPTH on every shift
  always_ff @(posedge C) begin
    if (!R && !FLUSH && EN) begin
      assert (int'(occ) + int'(VI) - int'(v[DEPTH-1]) >= 0);
      assert (int'(occ) + int'(VI) - int'(v[DEPTH-1]) <= DEPTH);
    end
  end
`endif
  specify
    specparam tpd = 4.2, tsetup = 2.5, thold = 0.9;
    (C *> Q) = (tpd, tpd);
    (C => VO) = (tpd, tpd);
    (C *> OCC) = (tpd, tpd);
    (TAP_SEL *> TAP, TAP_V) = (3.5, 3.5);
    $setup(D, posedge C, tsetup);
    $setup(VI, posedge C, tsetup);
    $setup(EN, posedge C, tsetup);
    $setup(R, posedge C, tsetup);
    $setup(FLUSH, posedge C, tsetup);
    $hold(posedge C, D, thold);
    $hold(posedge C, VI, thold);
    $hold(posedge C, EN, thold);
    $hold(posedge C, R, thold);
    $hold(posedge C, FLUSH, thold);
  endspecify
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: table, directed and random checks of dff_pipe against a history-queue model
`timescale 1ns/1ps
module tb_dff_pipe;
  localparam logic [7:0] RV = 8'h5A;
  logic C = 1'b0, R = 1'b1, EN = 1'b0, FLUSH = 1'b0, VI = 1'b0;
  logic [7:0] D = 8'h00;
  logic [1:0] TAP_SEL = 2'd0, TAP_SEL3 = 2'd0;
  logic [7:0] Q, TAP, Q3, TAP3;
  logic VO, TAP_V, VO3, TAP_V3;
  logic [2:0] OCC;
  logic [1:0] OCC3;
  int checks = 0, errors = 0;
  logic [8:0] hist [$];
  typedef struct {
    logic r, fl, en, vi;
    logic [7:0] d, q;
    logic vo;
    logic [2:0] occ;
  } vec_t;
  vec_t tbl [10];
  logic [7:0] tap_exp [4];
  logic tapv_exp [4];

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) dut (
    .C(C), .R(R), .EN(EN), .FLUSH(FLUSH), .D(D), .VI(VI), .Q(Q), .VO(VO),
    .TAP_SEL(TAP_SEL), .TAP(TAP), .TAP_V(TAP_V), .OCC(OCC));
  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) dut3 (
    .C(C), .R(R), .EN(EN), .FLUSH(FLUSH), .D(D), .VI(VI), .Q(Q3), .VO(VO3),
    .TAP_SEL(TAP_SEL3), .TAP(TAP3), .TAP_V(TAP_V3), .OCC(OCC3));

  always #5 C = ~C;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int occ_of(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(hist[i][8]);
    return c;
  endfunction

  // history model: hist[i] is the {valid,data} word entered i enabled edges ago
  task automatic model_edge();
    if (R) begin
      hist.delete();
      repeat (4) hist.push_back({1'b0, RV});
    end else if (FLUSH) begin
      foreach (hist[i]) hist[i][8] = 1'b0;
    end else if (EN) begin
      hist.push_front({VI, D});
      void'(hist.pop_back());
    end
  endtask

  task automatic check_all();
    chk("q", 32'(Q), 32'(hist[3][7:0]));
    chk("vo", 32'(VO), 32'(hist[3][8]));
    chk("occ", 32'(OCC), occ_of(4));
    chk("tap", 32'(TAP), 32'(hist[TAP_SEL][7:0]));
    chk("tap_v", 32'(TAP_V), 32'(hist[TAP_SEL][8]));
    chk("q3", 32'(Q3), 32'(hist[2][7:0]));
    chk("vo3", 32'(VO3), 32'(hist[2][8]));
    chk("occ3", 32'(OCC3), occ_of(3));
    chk("tap3", 32'(TAP3), TAP_SEL3 == 2'd3 ? 32'(RV) : 32'(hist[TAP_SEL3][7:0]));
    chk("tap_v3", 32'(TAP_V3), TAP_SEL3 == 2'd3 ? 32'd0 : 32'(hist[TAP_SEL3][8]));
  endtask

  task automatic step();
    @(posedge C);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic fl, input logic en, input logic vi, input logic [7:0] d);
    R = r; FLUSH = fl; EN = en; VI = vi; D = d;
  endtask

  initial begin
    repeat (4) hist.push_back(9'h0);
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 1'b1, 8'hEE, RV,    1'b0, 3'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, RV,    1'b0, 3'd0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, RV,    1'b0, 3'd1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 8'h22, RV,    1'b0, 3'd2},
      '{1'b0, 1'b0, 1'b1, 1'b1, 8'h33, RV,    1'b0, 3'd3},
      '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 8'h11, 1'b1, 3'd4},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 8'h22, 1'b1, 3'd3},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 8'h33, 1'b1, 3'd2},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h44, 1'b1, 3'd1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h88, 8'h55, 1'b0, 3'd0}};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].r, tbl[i].fl, tbl[i].en, tbl[i].vi, tbl[i].d);
      step();
      chk("tbl_q", 32'(Q), 32'(tbl[i].q));
      chk("tbl_vo", 32'(VO), 32'(tbl[i].vo));
      chk("tbl_occ", 32'(OCC), 32'(tbl[i].occ));
    end
    // stall with a full pipe
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hA1); step();
    D = 8'hA2; step();
    D = 8'hA3; step();
    D = 8'hA4; step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
      step();
      chk("stall_q", 32'(Q), 32'hA1);
      chk("stall_vo", 32'(VO), 32'd1);
      chk("stall_occ", 32'(OCC), 32'd4);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hB1); step();
    chk("resume_q", 32'(Q), 32'hA2);
    // flush while enabled at occupancy 3
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hC0); step();
    chk("pre_flush_occ", 32'(OCC), 32'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA); step();
    chk("flush_occ", 32'(OCC), 32'd0);
    chk("flush_vo", 32'(VO), 32'd0);
    chk("flush_q", 32'(Q), 32'hA3);
    TAP_SEL = 2'd0; #1;
    chk("flush_tap0", 32'(TAP), 32'hC0);
    chk("flush_tapv0", 32'(TAP_V), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step();
      chk("flush_drain_vo", 32'(VO), 32'd0);
    end
    // reset priority, and reset raised between edges has no early effect
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hD1); step();
    D = 8'hD2; step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    #3;
    chk("r_between_occ", 32'(OCC), 32'd2);
    chk("r_between_q", 32'(Q), 32'h00);
    step();
    chk("rst_occ", 32'(OCC), 32'd0);
    chk("rst_q", 32'(Q), 32'(RV));
    for (int s = 0; s < 4; s++) begin
      TAP_SEL = 2'(s); #1;
      chk("rst_tap", 32'(TAP), 32'(RV));
      chk("rst_tapv", 32'(TAP_V), 32'd0);
    end
    // tap sweep on a known fill, plus out-of-range select on the 3-deep pipe
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h10); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h20); step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h30); step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h40); step();
    EN = 1'b0;
    tap_exp = '{8'h40, 8'h30, 8'h20, 8'h10};
    tapv_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      TAP_SEL = 2'(s); TAP_SEL3 = 2'(s); #1;
      chk("sweep_tap", 32'(TAP), 32'(tap_exp[s]));
      chk("sweep_tapv", 32'(TAP_V), 32'(tapv_exp[s]));
      chk("sweep_tap3", 32'(TAP3), s == 3 ? 32'(RV) : 32'(tap_exp[s]));
      chk("sweep_tapv3", 32'(TAP_V3), s == 3 ? 32'd0 : 32'(tapv_exp[s]));
    end
    chk("sweep_occ", 32'(OCC), 32'd3);
    chk("sweep_occ3", 32'(OCC3), 32'd2);
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 9) < 7,
            1'($urandom), 8'($urandom));
      TAP_SEL = 2'($urandom);
      TAP_SEL3 = 2'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
